// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered onto the ALU, the result is captured and returned on a valid/ready channel.
module alu_arbiter #(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [1:0]         req0_opcode,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [1:0]         req1_opcode,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic [1:0]         alu_opcode,
  input  logic [DATA_W-1:0]  alu_o,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_id,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   grant_vld;
  logic   grant_id;
  logic   accept;
  logic   rsp_hs;

  function automatic logic [COUNT_W-1:0] count_inc(input logic [COUNT_W-1:0] cnt);
    count_inc = cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Arbitration: only looked at in IDLE; on contention the requester not served last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = !rst && grant_vld && !grant_id;
  assign req1_ready = !rst && grant_vld && grant_id;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_hs     = rsp_valid && rsp_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Issue stage: capture the granted operands onto the ALU inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_opcode <= '0;
      rsp_id     <= 1'b0;
    end else if (accept) begin
      last_grant <= grant_id;
      rsp_id     <= grant_id;
      alu_in1    <= grant_id ? req1_a      : req0_a;
      alu_in2    <= grant_id ? req1_b      : req0_b;
      alu_opcode <= grant_id ? req1_opcode : req0_opcode;
    end
  end

  // Response stage: capture the ALU result and hold it until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      op_count  <= '0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_o;
    end else if (state == RESP && rsp_hs) begin
      rsp_valid <= 1'b0;
      op_count  <= count_inc(op_count);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner-case sequences
// and randomized traffic checked against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]    req0_opcode, req1_opcode;
  logic [DW-1:0] alu_in1, alu_in2, alu_o;
  logic [1:0]    alu_opcode;
  logic          rsp_valid, rsp_ready, rsp_id, busy;
  logic [DW-1:0] rsp_data;
  logic [CW-1:0] op_count;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  typedef struct {
    bit         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    bit         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } op_t;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   alu_ref = a & b;
      2'b01:   alu_ref = ~a;
      2'b10:   alu_ref = a ^ b;
      default: alu_ref = a | b;
    endcase
  endfunction

  assign alu_o = alu_ref(alu_in1, alu_in2, alu_opcode);

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_opcode(req1_opcode),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_o(alu_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .op_count(op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Present one request, wait for its acceptance, then withdraw it.
  task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op);
    bit got = 1'b0;
    @(negedge clk);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_opcode = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_opcode = op;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", {31'd0, got}, 32'd1);
    if (got) begin
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      check("no_rsp_in_exec", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  // Called at the negedge right after acceptance; the response must appear one cycle later.
  task automatic finish(input bit id, input logic [7:0] exp);
    int lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    check("rsp_latency", lat, 32'd0);
    if (lat >= 0) begin
      check("rsp_data", {24'd0, rsp_data}, {24'd0, exp});
      check("rsp_id", {31'd0, rsp_id}, {31'd0, id});
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % 16;
      check("op_count", {28'd0, op_count}, exp_cnt);
      check("idle_after_rsp", {30'd0, busy, rsp_valid}, 32'd0);
    end
  endtask

  vec_t       vecs[8];
  vec_t       both_exp[3];
  op_t        q[$];
  op_t        e;
  bit         last_m, acc0, acc1, hs, drain, id;
  int         k;
  logic [7:0] ha, hb, hd;
  logic [1:0] hop;
  bit         hid;

  initial begin
    vecs[0] = '{1'b0, 8'hF0, 8'h3C, 2'b00, 8'h30};
    vecs[1] = '{1'b1, 8'h5A, 8'hFF, 2'b01, 8'hA5};
    vecs[2] = '{1'b0, 8'hAA, 8'h0F, 2'b10, 8'hA5};
    vecs[3] = '{1'b1, 8'h0F, 8'h30, 2'b11, 8'h3F};
    vecs[4] = '{1'b0, 8'h00, 8'hFF, 2'b00, 8'h00};
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 2'b10, 8'h00};
    vecs[6] = '{1'b0, 8'h81, 8'h00, 2'b01, 8'h7E};
    vecs[7] = '{1'b1, 8'h80, 8'h01, 2'b11, 8'h81};
    both_exp[0] = '{1'b0, 8'h0, 8'h0, 2'b00, 8'hA5};
    both_exp[1] = '{1'b1, 8'h0, 8'h0, 2'b00, 8'h3F};
    both_exp[2] = '{1'b0, 8'h0, 8'h0, 2'b00, 8'hA5};

    // Reset with both requesters asserting: no ready may leak out.
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_opcode = 2'b11;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_opcode = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check("rst_alu", {14'd0, alu_in1, alu_in2, alu_opcode}, 32'd0);
    check("rst_rsp", {22'd0, rsp_valid, rsp_id, rsp_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {28'd0, op_count}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // Directed vector table, one operation at a time.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      finish(vecs[i].id, vecs[i].exp);
    end

    // Both requesters valid from reset: grants must alternate starting with req0.
    do_reset();
    req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h0F; req0_opcode = 2'b10;
    req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h30; req1_opcode = 2'b11;
    rsp_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      #1;
      check("both_one_ready", {31'd0, req0_ready && req1_ready}, 32'd0);
      if (rsp_valid) begin
        check("both_id", {31'd0, rsp_id}, {31'd0, both_exp[k].id});
        check("both_data", {24'd0, rsp_data}, {24'd0, both_exp[k].exp});
        k++;
        exp_cnt++;
      end
      if (k < 3) @(negedge clk);
    end
    check("both_rsp_count", k, 32'd3);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("both_op_count", {28'd0, op_count}, exp_cnt);

    // Back-pressure: response held while req0 waits.
    issue(1'b0, 8'hC3, 8'h0F, 2'b00);
    @(negedge clk);
    check("bp_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_data0", {24'd0, rsp_data}, 32'h03);
    hd = rsp_data; hid = rsp_id;
    req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'hF0; req0_opcode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready_low", {31'd0, req0_ready}, 32'd0);
      check("bp_hold", {22'd0, rsp_valid, rsp_id, rsp_data}, {22'd0, 1'b1, hid, hd});
      check("bp_alu_hold", {14'd0, alu_in1, alu_in2, alu_opcode}, {14'd0, 8'hC3, 8'h0F, 2'b00});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 16;
    check("bp_count", {28'd0, op_count}, exp_cnt);
    check("bp_idle", {30'd0, busy, rsp_valid}, 32'd0);
    #1;
    check("bp_reaccept", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    finish(1'b0, 8'hFC);

    // Reset during EXEC drops the operation.
    issue(1'b1, 8'h5A, 8'hFF, 2'b01);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    check("mid_rst_state", {30'd0, busy, rsp_valid}, 32'd0);
    check("mid_rst_count", {28'd0, op_count}, 32'd0);
    check("mid_rst_alu", {14'd0, alu_in1, alu_in2, alu_opcode}, 32'd0);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) k++;
    end
    check("mid_rst_no_rsp", k, 32'd0);

    // Counter wrap: 16 completed operations bring the 4-bit count back to 0.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      id = i[0]; ha = 8'($urandom); hb = 8'($urandom); hop = 2'($urandom);
      if (i == 15) check("wrap_pre", {28'd0, op_count}, 32'd15);
      issue(id, ha, hb, hop);
      finish(id, alu_ref(ha, hb, hop));
    end
    check("wrap_zero", {28'd0, op_count}, 32'd0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    last_m = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drain = (cyc >= 360);
      if (!req0_valid && !drain && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1; req0_a = 8'($urandom); req0_b = 8'($urandom);
        req0_opcode = 2'($urandom);
      end
      if (!req1_valid && !drain && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1; req1_a = 8'($urandom); req1_b = 8'($urandom);
        req1_opcode = 2'($urandom);
      end
      rsp_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      check("rnd_one_ready", {31'd0, req0_ready && req1_ready}, 32'd0);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0 || acc1) begin
        id = acc1;
        check("rnd_no_overlap", q.size(), 32'd0);
        if (req0_valid && req1_valid) check("rnd_rr", {31'd0, id}, {31'd0, !last_m});
        last_m = id;
        if (id) q.push_back('{1'b1, req1_a, req1_b, req1_opcode});
        else    q.push_back('{1'b0, req0_a, req0_b, req0_opcode});
      end
      hs = rsp_valid && rsp_ready;
      if (hs) begin
        check("rnd_expected_rsp", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("rnd_id", {31'd0, rsp_id}, {31'd0, e.id});
          check("rnd_data", {24'd0, rsp_data}, {24'd0, alu_ref(e.a, e.b, e.op)});
          exp_cnt = (exp_cnt + 1) % 16;
        end
      end
      @(posedge clk);
      @(negedge clk);
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (hs) check("rnd_count", {28'd0, op_count}, exp_cnt);
    end
    check("rnd_drained", q.size() + {31'd0, req0_valid} + {31'd0, req1_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
